// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap/clear sequencer for a 2-digit BCD count-up counter, with an internal tick prescaler.
// Optional STOPWATCH_OVF_STOP_EN: saturate at 99 and force a halt instead of wrapping.
module stopwatch_ctrl #(
   parameter int DIV = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_stop,
   input  logic       lap_clear,
   input  logic [7:0] cnt_in,
   output logic       cnt_x,
   output logic       cnt_reset,
   output logic [7:0] disp_out,
   output logic       running,
   output logic       lap_held,
   output logic       overflow
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_LAP,
      S_STOP,
      S_LAP_STOP
   } state_t;

   state_t          r_state;
   logic [PW-1:0]   r_presc;
   logic            r_cnt_x;
   logic            r_cnt_reset;
   logic [7:0]      r_disp;
   logic            r_running;
   logic            r_lap_held;
   logic            r_overflow;

   state_t          w_state_next;
   logic            w_counting;
   logic            w_tick;
   logic            w_at_max;
   logic            w_clear;
   logic            w_tracking;

   assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
   assign w_tick     = w_counting && (r_presc == PMAX);
   assign w_at_max   = (cnt_in == 8'h99);
   assign w_clear    = (r_state == S_STOP) && !start_stop && lap_clear;
   assign w_tracking = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_STOP);

   // start_stop has priority; a simultaneous lap_clear is dropped
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE:     if (start_stop) w_state_next = S_RUN;
         S_RUN:      if (start_stop) w_state_next = S_STOP;
                     else if (lap_clear) w_state_next = S_LAP;
         S_LAP:      if (start_stop) w_state_next = S_LAP_STOP;
                     else if (lap_clear) w_state_next = S_RUN;
         S_STOP:     if (start_stop) w_state_next = S_RUN;
                     else if (lap_clear) w_state_next = S_IDLE;
         S_LAP_STOP: if (start_stop) w_state_next = S_LAP;
                     else if (lap_clear) w_state_next = S_STOP;
         default:    w_state_next = S_IDLE;
      endcase
`ifdef STOPWATCH_OVF_STOP_EN
      // A tick at 99 halts the run, keeping any held lap frozen
      if (w_tick && w_at_max) begin
         if ((w_state_next == S_LAP) || (w_state_next == S_LAP_STOP))
            w_state_next = S_LAP_STOP;
         else
            w_state_next = S_STOP;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_presc     <= '0;
         r_cnt_x     <= 1'b0;
         r_cnt_reset <= 1'b0;
         r_disp      <= 8'h00;
         r_running   <= 1'b0;
         r_lap_held  <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_running   <= (w_state_next == S_RUN) || (w_state_next == S_LAP);
         r_lap_held  <= (w_state_next == S_LAP) || (w_state_next == S_LAP_STOP);
         r_cnt_reset <= w_clear;

         if (w_clear || w_tick)
            r_presc <= '0;
         else if (w_counting)
            r_presc <= r_presc + PW'(1);

`ifdef STOPWATCH_OVF_STOP_EN
         r_cnt_x <= w_tick && !w_at_max;
`else
         r_cnt_x <= w_tick;
`endif

         if (w_clear)
            r_overflow <= 1'b0;
         else if (w_tick && w_at_max)
            r_overflow <= 1'b1;

         if (w_tracking)
            r_disp <= cnt_in;
      end
   end

   assign cnt_x     = r_cnt_x;
   assign cnt_reset = r_cnt_reset;
   assign disp_out  = r_disp;
   assign running   = r_running;
   assign lap_held  = r_lap_held;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button traffic against a mode-flag model,
// with a behavioural BCD counter closing the loop on cnt_x / cnt_reset.
module tb_stopwatch_ctrl;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_stop = 1'b0;
   logic       lap_clear = 1'b0;
   logic [7:0] cnt = 8'h00;
   logic       cnt_x;
   logic       cnt_reset;
   logic [7:0] disp_out;
   logic       running;
   logic       lap_held;
   logic       overflow;

   int n_cmp = 0;
   int n_bad = 0;

   // model: stopwatch as three flags rather than a five-state machine
   bit         m_idle = 1, m_run = 0, m_frozen = 0;
   int         m_presc = 0;
   logic [7:0] m_disp = 8'h00;
   bit         m_x = 0, m_clr = 0, m_ovf = 0;

   stopwatch_ctrl #(.DIV(DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_stop (start_stop),
      .lap_clear  (lap_clear),
      .cnt_in     (cnt),
      .cnt_x      (cnt_x),
      .cnt_reset  (cnt_reset),
      .disp_out   (disp_out),
      .running    (running),
      .lap_held   (lap_held),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
      if (v[7:4] != 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return 8'h00;
   endfunction

   task automatic model(input bit ss, input bit lc, input bit rst, input logic [7:0] c);
      bit tick, wrap;
      if (rst) begin
         m_idle = 1; m_run = 0; m_frozen = 0; m_presc = 0;
         m_disp = 8'h00; m_x = 0; m_clr = 0; m_ovf = 0;
         return;
      end
      tick = m_run && (m_presc == DIV - 1);
      wrap = tick && (c == 8'h99);
      if (!m_frozen) m_disp = c;
      m_x = tick;
      if (wrap) m_ovf = 1;
      if (m_run) m_presc = tick ? 0 : m_presc + 1;
      m_clr = lc && !ss && !m_idle && !m_run && !m_frozen;
      if (ss) begin
         if (m_idle) begin m_idle = 0; m_run = 1; end
         else m_run = !m_run;
      end else if (lc && !m_idle) begin
         if (m_frozen) m_frozen = 0;
         else if (m_run) m_frozen = 1;
         else begin m_idle = 1; m_presc = 0; m_ovf = 0; end
      end
`ifdef STOPWATCH_OVF_STOP_EN
      if (wrap) begin m_x = 0; m_run = 0; end
`endif
   endtask

   // one clock cycle: drive pulses, advance counter and model, compare every output
   task automatic step(input bit ss, input bit lc, input bit rst);
      logic [7:0] c_pre;
      logic       x_pre, r_pre;
      @(negedge clk);
      start_stop = ss; lap_clear = lc; reset = rst;
      c_pre = cnt; x_pre = cnt_x; r_pre = cnt_reset;
      @(posedge clk);
      #1;
      start_stop = 1'b0; lap_clear = 1'b0; reset = 1'b0;
      if (rst || r_pre === 1'b1) cnt = 8'h00;
      else if (x_pre === 1'b1) cnt = bcd_inc(cnt);
      model(ss, lc, rst, c_pre);
      chk("cnt_x", cnt_x, m_x);
      chk("cnt_reset", cnt_reset, m_clr);
      chk("disp_out", disp_out, m_disp);
      chk("running", running, m_run);
      chk("lap_held", lap_held, m_frozen);
      chk("overflow", overflow, m_ovf);
      if (ss || lc || rst)
         $display("t=%0t ss=%b lc=%b rst=%b cnt=%h disp=%h run=%b lap=%b ovf=%b",
                  $time, ss, lc, rst, cnt, disp_out, running, lap_held, overflow);
   endtask

   task automatic run_until(input logic [7:0] target, input int limit);
      int n = 0;
      while (cnt !== target && n < limit) begin
         step(0, 0, 0);
         n++;
      end
      chk("reach_count", cnt, target);
   endtask

   initial begin
      int n;
      bit rs, rl, rr;

      // reset state
      repeat (3) step(0, 0, 1);
      chk("rst_disp", disp_out, 8'h00);
      chk("rst_running", running, 1'b0);
      chk("rst_cnt_x", cnt_x, 1'b0);

      // start; five ticks then one cycle of display lag
      step(1, 0, 0);
      chk("start_running", running, 1'b1);
      repeat (22) step(0, 0, 0);
      chk("disp_after_5_ticks", disp_out, 8'h05);

      // lap freeze at 12, release at 15
      run_until(8'h12, 100);
      step(0, 1, 0);
      chk("lap_latch", disp_out, 8'h12);
      run_until(8'h15, 40);
      chk("lap_frozen_disp", disp_out, 8'h12);
      chk("lap_flag", lap_held, 1'b1);
      step(0, 1, 0);
      step(0, 0, 0);
      chk("lap_release_disp", disp_out, 8'h15);
      chk("lap_release_flag", lap_held, 1'b0);

      // stop mid-tick, idle, resume keeps partial tick
      n = 0;
      while (m_presc != 1 && n < 10) begin step(0, 0, 0); n++; end
      step(1, 0, 0);
      repeat (10) begin
         step(0, 0, 0);
         chk("stopped_no_tick", cnt_x, 1'b0);
      end
      step(1, 0, 0);
      step(0, 0, 0);
      chk("resume_wait", cnt_x, 1'b0);
      step(0, 0, 0);
      chk("resume_tick", cnt_x, 1'b1);

      // stop at 37 then clear
      run_until(8'h37, 200);
      step(1, 0, 0);
      step(0, 1, 0);
      chk("clear_pulse", cnt_reset, 1'b1);
      chk("clear_no_tick", cnt_x, 1'b0);
      step(0, 0, 0);
      chk("clear_pulse_end", cnt_reset, 1'b0);
      step(0, 0, 0);
      chk("clear_disp", disp_out, 8'h00);
      chk("clear_ovf", overflow, 1'b0);

      // run through 99
      step(1, 0, 0);
      run_until(8'h99, 600);
      repeat (DIV + 2) step(0, 0, 0);
      chk("ovf_flag", overflow, 1'b1);
`ifdef STOPWATCH_OVF_STOP_EN
      chk("ovf_saturate", cnt, 8'h99);
      chk("ovf_halt", running, 1'b0);
`else
      chk("ovf_wrap", cnt, 8'h00);
      chk("ovf_keep_running", running, 1'b1);
`endif

      // simultaneous pulses from RUN: start_stop wins
      if (m_run) step(1, 0, 0);
      step(0, 1, 0);
      step(1, 0, 0);
      repeat (3) step(0, 0, 0);
      step(1, 1, 0);
      chk("both_running", running, 1'b0);
      chk("both_lap", lap_held, 1'b0);

      // reset while in LAP
      step(1, 0, 0);
      step(0, 1, 0);
      chk("pre_reset_lap", lap_held, 1'b1);
      repeat (3) step(0, 0, 0);
      step(0, 0, 1);
      chk("lap_rst_running", running, 1'b0);
      chk("lap_rst_lap", lap_held, 1'b0);
      chk("lap_rst_disp", disp_out, 8'h00);
      chk("lap_rst_cnt_x", cnt_x, 1'b0);

      // random button traffic
      for (int i = 0; i < 2000; i++) begin
         rs = ($urandom_range(15) == 0);
         rl = ($urandom_range(15) == 0);
         rr = ($urandom_range(255) == 0);
         step(rs, rl, rr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
